// File: rtl/smp_snoop_bus_ctrl.sv
// Shared-bus MSI snoop controller for NUM_CORES private caches: round-robin arbitration,
// snoop broadcast, then either an owner flush or a memory fetch, ending in a done pulse.
module smp_snoop_bus_ctrl #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [2*NUM_CORES-1:0]        req_op,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  output logic [NUM_CORES-1:0]          grant,
  output logic [NUM_CORES-1:0]          done,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          snoop_valid,
  output logic [1:0]                    snoop_op,
  output logic [ADDR_W-1:0]             snoop_addr,
  output logic [IDX_W-1:0]              snoop_src,
  input  logic [NUM_CORES-1:0]          snoop_hit_mod,
  input  logic [NUM_CORES*DATA_W-1:0]   snoop_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_rdy,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          err_multi_owner
);

  localparam int unsigned CW = IDX_W + 1;

  localparam logic [1:0] OP_READ_MISS  = 2'b00;
  localparam logic [1:0] OP_WRITE_MISS = 2'b01;
  localparam logic [1:0] OP_INVALIDATE = 2'b10;
  localparam logic [1:0] OP_RESERVED   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_FLUSH,
    S_MEM_RD,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_d;

  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win;
  logic [1:0]          op;
  logic [ADDR_W-1:0]   addr;

  logic                arb_found;
  logic [IDX_W-1:0]    arb_idx;
  logic [1:0]          arb_op;
  logic [ADDR_W-1:0]   arb_addr;
  logic [CW-1:0]       cand;

  logic [NUM_CORES-1:0] hits;
  logic                 hit_any;
  logic                 hit_multi;
  logic [DATA_W-1:0]    hit_data;

  // Round-robin pick: first requesting core at or after ptr, wrapping.
  always_comb begin : arbiter
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_op    = '0;
    arb_addr  = '0;
    cand      = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      cand = CW'(ptr) + CW'(i);
      if (cand >= CW'(NUM_CORES)) begin
        cand = cand - CW'(NUM_CORES);
      end
      if (!arb_found && req[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
        arb_op    = req_op[int'(cand)*2 +: 2];
        arb_addr  = req_addr[int'(cand)*int'(ADDR_W) +: ADDR_W];
      end
    end
  end

  // Modified-owner resolution; the requester's own reply is ignored, lowest index wins.
  always_comb begin : snoop_resolve
    hits      = snoop_hit_mod & ~(NUM_CORES'(1) << win);
    hit_any   = |hits;
    hit_multi = |(hits & (hits - NUM_CORES'(1)));
    hit_data  = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit_data = snoop_data[i*int'(DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin : next_state
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (arb_found) begin
          state_d = (arb_op == OP_RESERVED) ? S_DONE : S_SNOOP;
        end
      end
      S_SNOOP: begin
        if (op == OP_INVALIDATE) begin
          state_d = S_DONE;
        end else if (hit_any) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_FLUSH: begin
        if (mem_rdy) begin
          state_d = S_DONE;
        end
      end
      S_MEM_RD: begin
        if (mem_rdy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Transaction latches, bus-side outputs and the completion bookkeeping.
  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      ptr             <= '0;
      win             <= '0;
      op              <= '0;
      addr            <= '0;
      grant           <= '0;
      rd_data         <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      err_multi_owner <= 1'b0;
    end else begin
      mem_req <= (state_d == S_FLUSH) || (state_d == S_MEM_RD);
      mem_we  <= (state_d == S_FLUSH);
      unique case (state)
        S_IDLE: begin
          if (arb_found) begin
            win   <= arb_idx;
            op    <= arb_op;
            addr  <= arb_addr;
            grant <= NUM_CORES'(1) << arb_idx;
          end
        end
        S_SNOOP: begin
          mem_addr <= addr;
          if (op != OP_INVALIDATE && hit_any) begin
            mem_wdata <= hit_data;
          end
          if (hit_multi) begin
            err_multi_owner <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (mem_rdy) begin
            rd_data <= mem_wdata;
          end
        end
        S_MEM_RD: begin
          if (mem_rdy) begin
            rd_data <= mem_rdata;
          end
        end
        S_DONE: begin
          grant <= '0;
          ptr   <= (win == IDX_W'(NUM_CORES - 1)) ? '0 : win + IDX_W'(1);
        end
        default: begin
          grant <= '0;
        end
      endcase
    end
  end

  assign done        = (state == S_DONE) ? grant : '0;
  assign snoop_valid = (state == S_SNOOP);
  assign snoop_op    = op;
  assign snoop_addr  = addr;
  assign snoop_src   = win;

endmodule

// File: tb/tb_smp_snoop_bus_ctrl.sv
// Scoreboard bench for smp_snoop_bus_ctrl: directed transactions push expected snoops,
// memory accesses and completions; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_smp_snoop_bus_ctrl;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [IW-1:0] src;
  } snoop_exp_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic [NC-1:0] done;
    logic [DW-1:0] rd_data;
    logic          err;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0]    req;
  logic [2*NC-1:0]  req_op;
  logic [NC*AW-1:0] req_addr;
  logic [NC-1:0]    grant;
  logic [NC-1:0]    done;
  logic [DW-1:0]    rd_data;
  logic             snoop_valid;
  logic [1:0]       snoop_op;
  logic [AW-1:0]    snoop_addr;
  logic [IW-1:0]    snoop_src;
  logic [NC-1:0]    snoop_hit_mod;
  logic [NC*DW-1:0] snoop_data;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_rdy = 1'b0;
  logic [DW-1:0]    mem_rdata;
  logic             err_multi_owner;

  logic [DW-1:0] mem_word;
  int mem_lat;
  int mem_cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  snoop_exp_t snoop_q[$];
  mem_exp_t   mem_q[$];
  done_exp_t  done_q[$];

  smp_snoop_bus_ctrl #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
    .grant(grant), .done(done), .rd_data(rd_data),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_src(snoop_src), .snoop_hit_mod(snoop_hit_mod), .snoop_data(snoop_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .err_multi_owner(err_multi_owner)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_snoop(input logic [1:0] o, input logic [AW-1:0] a, input logic [IW-1:0] s);
    snoop_exp_t e;
    e.op = o; e.addr = a; e.src = s;
    snoop_q.push_back(e);
  endtask

  task automatic exp_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_exp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    mem_q.push_back(e);
  endtask

  task automatic exp_done(input logic [NC-1:0] d, input logic [DW-1:0] r, input logic er);
    done_exp_t e;
    e.done = d; e.rd_data = r; e.err = er;
    done_q.push_back(e);
  endtask

  task automatic set_core(input int c, input logic [1:0] o, input logic [AW-1:0] a);
    req_op[c*2 +: 2]    = o;
    req_addr[c*AW +: AW] = a;
  endtask

  // Raise one request, wait (bounded) for its done pulse, drop req, check latency.
  task automatic run_txn(input int c, input logic [1:0] o, input logic [AW-1:0] a,
                         input int exp_lat, input string name);
    int n = 0;
    set_core(c, o, a);
    req[c] = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (done[c]) break;
    end
    req[c] = 1'b0;
    check(name, 32'(n), 32'(exp_lat));
  endtask

  // Snoop monitor
  always @(negedge clk) begin
    if (!rst && snoop_valid === 1'b1) begin
      check("snoop_expected", 32'(snoop_q.size() > 0), 1);
      if (snoop_q.size() > 0) begin
        snoop_exp_t e;
        e = snoop_q.pop_front();
        check("snoop_op", 32'(snoop_op), 32'(e.op));
        check("snoop_addr", 32'(snoop_addr), 32'(e.addr));
        check("snoop_src", 32'(snoop_src), 32'(e.src));
      end
    end
  end

  // Memory model and monitor: every active cycle is compared, entry retired on mem_rdy.
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      check("mem_expected", 32'(mem_q.size() > 0), 1);
      if (mem_q.size() > 0) begin
        check("mem_we", 32'(mem_we), 32'(mem_q[0].we));
        check("mem_addr", 32'(mem_addr), 32'(mem_q[0].addr));
        if (mem_q[0].we) check("mem_wdata", 32'(mem_wdata), 32'(mem_q[0].wdata));
      end
      if (mem_cyc >= mem_lat) begin
        mem_rdy = 1'b1;
        mem_cyc = 0;
        if (mem_q.size() > 0) void'(mem_q.pop_front());
      end else begin
        mem_rdy = 1'b0;
        mem_cyc++;
      end
    end else begin
      mem_rdy = 1'b0;
      mem_cyc = 0;
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (!rst && (|done) === 1'b1) begin
      check("done_expected", 32'(done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        done_exp_t e;
        e = done_q.pop_front();
        check("done_vec", 32'(done), 32'(e.done));
        check("done_grant", 32'(grant), 32'(e.done));
        check("done_rd_data", 32'(rd_data), 32'(e.rd_data));
        check("done_err", 32'(err_multi_owner), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    int got[3];
    logic [NC-1:0] pend;

    rst = 1'b1; req = '0; req_op = '0; req_addr = '0;
    snoop_hit_mod = '0; snoop_data = '0; mem_lat = 0; mem_word = '0;
    got = '{default: 0};
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_snoop_valid", 32'(snoop_valid), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_err", 32'(err_multi_owner), 0);
    rst = 1'b0;
    @(negedge clk);

    // Core1 READ_MISS, no owner, memory ready immediately
    mem_word = 16'hBEEF; mem_lat = 0;
    exp_snoop(2'b00, 16'h0040, 2'd1);
    exp_mem(1'b0, 16'h0040, 16'h0000);
    exp_done(4'b0010, 16'hBEEF, 1'b0);
    run_txn(1, 2'b00, 16'h0040, 3, "lat_read_miss");

    // Reset while MEM_RD is stalled
    mem_lat = 1000;
    exp_snoop(2'b00, 16'h0050, 2'd1);
    exp_mem(1'b0, 16'h0050, 16'h0000);
    set_core(1, 2'b00, 16'h0050);
    req[1] = 1'b1;
    n = 0;
    while (n < 20 && mem_req !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("midrd_mem_req", 32'(mem_req), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    req = '0;
    check("midrd_rst_grant", 32'(grant), 0);
    check("midrd_rst_mem_req", 32'(mem_req), 0);
    check("midrd_rst_done", 32'(done), 0);
    check("midrd_rst_snoop_valid", 32'(snoop_valid), 0);
    check("midrd_rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    mem_q.delete();
    mem_lat = 0;
    @(negedge clk);
    check("midrd_idle_grant", 32'(grant), 0);

    // Core0 WRITE_MISS, core2 owns MODIFIED, memory stalls 2 cycles
    snoop_hit_mod = 4'b0100;
    snoop_data[2*DW +: DW] = 16'h1234;
    mem_lat = 2;
    exp_snoop(2'b01, 16'h0100, 2'd0);
    exp_mem(1'b1, 16'h0100, 16'h1234);
    exp_done(4'b0001, 16'h1234, 1'b0);
    run_txn(0, 2'b01, 16'h0100, 5, "lat_flush_wait");
    snoop_hit_mod = '0;
    mem_lat = 0;
    @(negedge clk);

    // Pointer=1: cores 0,2,3 contend, expected order 2,3,0
    mem_word = 16'h3C3C;
    set_core(0, 2'b00, 16'h0200);
    set_core(2, 2'b00, 16'h0220);
    set_core(3, 2'b00, 16'h0230);
    exp_snoop(2'b00, 16'h0220, 2'd2);
    exp_snoop(2'b00, 16'h0230, 2'd3);
    exp_snoop(2'b00, 16'h0200, 2'd0);
    exp_mem(1'b0, 16'h0220, 16'h0000);
    exp_mem(1'b0, 16'h0230, 16'h0000);
    exp_mem(1'b0, 16'h0200, 16'h0000);
    exp_done(4'b0100, 16'h3C3C, 1'b0);
    exp_done(4'b1000, 16'h3C3C, 1'b0);
    exp_done(4'b0001, 16'h3C3C, 1'b0);
    pend = 4'b1101;
    req  = 4'b1101;
    n = 0; k = 0;
    while (pend != '0 && n < 60) begin
      @(negedge clk);
      n++;
      for (int c = 0; c < int'(NC); c++) begin
        if (done[c] && pend[c]) begin
          req[c]  = 1'b0;
          pend[c] = 1'b0;
          if (k < 3) got[k] = c;
          k++;
        end
      end
    end
    req = '0;
    check("rr_all_served", 32'(pend), 0);
    check("rr_order_0", 32'(got[0]), 2);
    check("rr_order_1", 32'(got[1]), 3);
    check("rr_order_2", 32'(got[2]), 0);
    check("rr_total_cycles", 32'(n), 11);
    @(negedge clk);

    // Core3 INVALIDATE, core1 MODIFIED: no memory traffic, rd_data untouched
    snoop_hit_mod = 4'b0010;
    snoop_data[1*DW +: DW] = 16'hDEAD;
    exp_snoop(2'b10, 16'h0080, 2'd3);
    exp_done(4'b1000, 16'h3C3C, 1'b0);
    run_txn(3, 2'b10, 16'h0080, 2, "lat_invalidate");
    snoop_hit_mod = '0;
    @(negedge clk);

    // Core0 READ_MISS with two foreign owners plus its own stale hit bit
    snoop_hit_mod = 4'b0111;
    snoop_data[0*DW +: DW] = 16'hFFFF;
    snoop_data[1*DW +: DW] = 16'hAAAA;
    snoop_data[2*DW +: DW] = 16'h5555;
    exp_snoop(2'b00, 16'h0300, 2'd0);
    exp_mem(1'b1, 16'h0300, 16'hAAAA);
    exp_done(4'b0001, 16'hAAAA, 1'b1);
    run_txn(0, 2'b00, 16'h0300, 3, "lat_multi_owner");
    snoop_hit_mod = '0;
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err_multi_owner), 1);

    // Core2 reserved op: straight to done, nothing snooped or fetched
    exp_done(4'b0100, 16'hAAAA, 1'b1);
    run_txn(2, 2'b11, 16'h0400, 1, "lat_reserved");
    @(negedge clk);

    rst = 1'b1;
    @(negedge clk);
    check("final_rst_err", 32'(err_multi_owner), 0);
    check("final_rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    @(negedge clk);

    check("snoop_q_drained", 32'(snoop_q.size()), 0);
    check("mem_q_drained", 32'(mem_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
